// File: rtl/serial_subtractor_if.sv
// Run/Done handshake and operand/result bus for the bit-serial subtractor.
// The controller drives the master side; the subtractor sits on the slave side.
interface serial_subtractor_if #(
   parameter int unsigned N = 16
);
   logic         Run;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [N-1:0] Diff;
   logic         Borrow_out;
   logic         Overflow;
   logic         Busy;
   logic         Done;

   modport master (
      output Run, A, B,
      input  Diff, Borrow_out, Overflow, Busy, Done
   );

   modport slave (
      input  Run, A, B,
      output Diff, Borrow_out, Overflow, Busy, Done
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B computed LSB first as A + ~B + 1
// through one full-adder slice with a registered carry, under a Run/Done handshake.
module serial_subtractor #(
   parameter int unsigned N = 16
) (
   input  logic              Clk,
   input  logic              Reset_n,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CW = $clog2(N + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  a_sh_q, a_sh_d;
   logic [N-1:0]  b_sh_q, b_sh_d;
   logic [N-1:0]  diff_q, diff_d;
   logic          carry_q, carry_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          a_msb_q, a_msb_d;
   logic          b_msb_q, b_msb_d;
   logic          borrow_q, borrow_d;
   logic          ovf_q, ovf_d;

   // Full-adder slice fed with the inverted subtrahend bit.
   logic a_bit, nb_bit, sum_bit, carry_nxt;

   always_comb begin
      a_bit     = a_sh_q[0];
      nb_bit    = ~b_sh_q[0];
      sum_bit   = a_bit ^ nb_bit ^ carry_q;
      carry_nxt = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.Run) begin
               a_sh_d  = bus.A;
               b_sh_d  = bus.B;
               a_msb_d = bus.A[N-1];
               b_msb_d = bus.B[N-1];
               carry_d = 1'b1;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            diff_d  = {sum_bit, diff_q[N-1:1]};
            a_sh_d  = {1'b0, a_sh_q[N-1:1]};
            b_sh_d  = {1'b0, b_sh_q[N-1:1]};
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               // sum_bit is the result MSB landing in Diff[N-1] on this edge.
               borrow_d = ~carry_nxt;
               ovf_d    = (a_msb_q != b_msb_q) & (sum_bit != a_msb_q);
               state_d  = DONE;
            end
         end

         DONE: begin
            if (!bus.Run) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         diff_q   <= diff_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.Diff       = diff_q;
   assign bus.Borrow_out = borrow_q;
   assign bus.Overflow   = ovf_q;
   assign bus.Busy       = (state_q == SHIFT);
   assign bus.Done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

   localparam int unsigned N = 16;

   logic Clk = 1'b0;
   logic Reset_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   serial_subtractor_if #(.N(N)) bus ();

   serial_subtractor #(.N(N)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [N-1:0] m_diff(input logic [N-1:0] a, input logic [N-1:0] b);
      return a - b;
   endfunction

   function automatic logic m_borrow(input logic [N-1:0] a, input logic [N-1:0] b);
      return (a < b);
   endfunction

   function automatic logic m_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
      int sa, sb, d;
      sa = int'($signed(a));
      sb = int'($signed(b));
      d  = sa - sb;
      return (d > (2 ** (N - 1)) - 1) || (d < -(2 ** (N - 1)));
   endfunction

   // Called right after the start edge; waits for Done and checks result and latency.
   task automatic finish_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      int edges, busy_cyc;
      edges = 1;
      busy_cyc = 0;
      check({tag, ".busy_after_start"}, 32'(bus.Busy), 32'd1);
      if (bus.Busy) busy_cyc = 1;
      while (!bus.Done && edges < 100) begin
         tick();
         edges++;
         if (bus.Busy) busy_cyc++;
      end
      check({tag, ".latency"}, 32'(edges), 32'(N + 1));
      check({tag, ".busy_cycles"}, 32'(busy_cyc), 32'(N));
      check({tag, ".diff"}, 32'(bus.Diff), 32'(m_diff(a, b)));
      check({tag, ".borrow"}, 32'(bus.Borrow_out), 32'(m_borrow(a, b)));
      check({tag, ".ovf"}, 32'(bus.Overflow), 32'(m_ovf(a, b)));
   endtask

   task automatic release_run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      bus.Run = 1'b0;
      tick();
      check({tag, ".done_fall"}, 32'(bus.Done), 32'd0);
      check({tag, ".idle_hold"}, 32'(bus.Diff), 32'(m_diff(a, b)));
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      bus.A = a;
      bus.B = b;
      bus.Run = 1'b1;
      tick();
      finish_op(tag, a, b);
      release_run(tag, a, b);
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      bus.Run = 1'b1;
      bus.A = 16'h0005;
      bus.B = 16'h0003;
      #1 Reset_n = 1'b0;
      #3;
      check("rst.diff", 32'(bus.Diff), 32'd0);
      check("rst.borrow", 32'(bus.Borrow_out), 32'd0);
      check("rst.ovf", 32'(bus.Overflow), 32'd0);
      check("rst.busy", 32'(bus.Busy), 32'd0);
      check("rst.done", 32'(bus.Done), 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      // Release with Run already high: the next rising edge is the start edge.
      Reset_n = 1'b1;
      tick();
      finish_op("d5m3", 16'h0005, 16'h0003);
      release_run("d5m3", 16'h0005, 16'h0003);

      run_op("d3m5", 16'h0003, 16'h0005);
      run_op("d8000m1", 16'h8000, 16'h0001);
      run_op("d7fffmffff", 16'h7FFF, 16'hFFFF);
      run_op("d0m0", 16'h0000, 16'h0000);
      run_op("dffffmffff", 16'hFFFF, 16'hFFFF);

      // Asynchronous reset mid-operation, between edges.
      bus.A = 16'h1234;
      bus.B = 16'h0034;
      bus.Run = 1'b1;
      tick();
      bus.Run = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      #2 Reset_n = 1'b0;
      #1;
      check("midrst.diff", 32'(bus.Diff), 32'd0);
      check("midrst.borrow", 32'(bus.Borrow_out), 32'd0);
      check("midrst.ovf", 32'(bus.Overflow), 32'd0);
      check("midrst.busy", 32'(bus.Busy), 32'd0);
      check("midrst.done", 32'(bus.Done), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      tick();
      check("midrst.stays_idle", 32'(bus.Busy), 32'd0);
      run_op("d10m1", 16'h0010, 16'h0001);

      // Run held through DONE while operands change: result must not move.
      bus.A = 16'h0009;
      bus.B = 16'h0004;
      bus.Run = 1'b1;
      tick();
      bus.A = 16'hFFFF;
      bus.B = 16'h0001;
      finish_op("hold", 16'h0009, 16'h0004);
      for (int i = 0; i < 6; i++) tick();
      check("hold.done", 32'(bus.Done), 32'd1);
      check("hold.busy", 32'(bus.Busy), 32'd0);
      check("hold.diff", 32'(bus.Diff), 32'h0005);
      release_run("hold", 16'h0009, 16'h0004);
      run_op("second", 16'hFFFF, 16'h0001);

      for (int i = 0; i < 24; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         if (i % 6 == 0) rb = ra;
         if (i % 6 == 1) ra = {1'b1, {(N-1){1'b0}}};
         run_op($sformatf("rnd%0d", i), ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
